csi2_short_pkt_tracker: RTL and testbench
=========================================

# csi2_short_pkt_tracker

Per-virtual-channel short-packet tracker for the CSI-2 receive path. It sits after header ECC/CRC correction and decodes frame/line sync short packets (FS, FE, LS, LE) and generic short packets for `NUM_VC` virtual channels. For each channel it runs a frame/line state machine, tracks frame and line numbers, counts lines per frame, and flags protocol-sequence errors. All outputs are registered, so downstream pixel-unpacking and timing-generation logic sees clean, single-cycle strobes.

## Interface
Parameters:
- `NUM_VC`, 4: number of tracked virtual channels (1–4).
- `LINE_CNT_W`, 16: width of the per-frame line counter.
- `FRAME_NUM_MAX`, 16'hFFFF: largest frame number before wrap to 1.

Ports:
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `header_valid_i` in 1: one-cycle strobe, header fields valid.
- `virtual_channel_i` in 2: VC of the header.
- `data_type_i` in 6: CSI-2 data type.
- `data_field_i` in 16: short-packet data field.
- `frame_start_o` / `frame_end_o` / `line_start_o` / `line_end_o` out 1 each: registered strobes.
- `vc_o` out 2: VC qualifying the strobes, generic packet and error.
- `frame_number_o` out 16*NUM_VC: last FS data field, per VC (VC0 in LSBs).
- `line_number_o` out 16*NUM_VC: last LS data field, per VC.
- `in_frame_o` out NUM_VC: VC state is not IDLE.
- `last_frame_lines_o` out LINE_CNT_W*NUM_VC: LS count of the last completed frame.
- `generic_valid_o` out 1: strobe for generic short packet (DT 0x08–0x0F).
- `generic_dt_o` out 3: DT[2:0] of the generic packet.
- `generic_data_o` out 16: data field of the generic packet.
- `err_o` out 1: protocol-error strobe.
- `err_code_o` out 3: error code, valid with `err_o`.

## Operation
- Packets are accepted only when `header_valid_i` = 1. A header with `virtual_channel_i` >= NUM_VC is ignored entirely, with no strobe and no error.
- Per-VC FSM with states IDLE, IN_FRAME, IN_LINE:
  - **IDLE**, FS → IN_FRAME: load frame number, clear line counter.
  - **IN_FRAME**, LS → IN_LINE: load line number, increment line counter.
  - **IN_LINE**, LE → IN_FRAME.
  - **IN_FRAME**, FE → IDLE: latch line counter into `last_frame_lines`.
- Error codes and recovery:
  - FS in IN_FRAME/IN_LINE → `FS_IN_FRAME` (1). Restart the frame: load frame number, clear counter, go to IN_FRAME.
  - FE in IDLE → `FE_NO_FS` (2). Stay in IDLE.
  - FE in IN_LINE → `LINE_UNTERM` (3). Close the frame as a normal FE.
  - LS in IDLE → `LS_NO_FS` (4). No count, stay in IDLE; `line_number` is still loaded.
  - LS in IN_LINE → `LS_IN_LINE` (5). Count it as a new line, stay in IN_LINE.
  - LE in IDLE/IN_FRAME → `LE_NO_LS` (6). No state change.
- Sync strobes fire for every accepted FS/FE/LS/LE, including those that also raise an error.
- The line counter saturates at all-ones and never wraps.
- Other data types (long packets, reserved types) are ignored.

## Timing
- Latency is one cycle: header at cycle N produces strobes, `vc_o`, errors, generic outputs and updated registers at cycle N+1.
- Every strobe is high for exactly one cycle per header. Back-to-back headers on consecutive cycles are fully supported, with no stall and no backpressure.
- Reset values: all strobes 0; `vc_o`, numbers, counters, `last_frame_lines_o`, generic fields and `err_code_o` all 0; every FSM in IDLE; `in_frame_o` = 0.
- Reset asserted mid-frame returns all channels to IDLE immediately. No FE is emitted and no counter is latched.
- `err_code_o` holds its value between errors. `vc_o` updates on every accepted header.

## Configuration
- **`CSI2_FRAME_NUM_CHECK_EN` defined:**
  - On FS whose data field is nonzero and whose previous frame number is nonzero, the value must equal previous+1.
  - After `FRAME_NUM_MAX`, the expected value is 1.
  - A mismatch raises `FRAME_NUM_SEQ` (7) in the same cycle as the FS strobe.
  - If `FS_IN_FRAME` also applies, `FS_IN_FRAME` takes priority.
- **Not defined:** no sequence logic is built, and code 7 is never produced.

## Structure
- Add the following to `csi2_data_types_pkg`:
  - `vc_state_t` enum (IDLE, IN_FRAME, IN_LINE).
  - `short_pkt_err_t` enum (codes 0–7).
  - `GENERIC_SHORT_MIN`/`GENERIC_SHORT_MAX` constants.
- Reuse the existing FRAME_START/FRAME_END/LINE_START/LINE_END.
- Sub-module `csi2_vc_frame_fsm`: one instance per VC via generate. It holds the state, numbers, counter and the error decision. The top level does decode, VC select and output registering.

## Test plan
- **Normal frame on VC0:** FS(5), 3×(LS n/LE), FE. Expect:
  - `frame_number` = 5, `line_number` = 3, `last_frame_lines` = 3.
  - Each strobe exactly one cycle after its header; `err_o` never asserted.
- **Interleaved VC1/VC2:** FS on both, then alternating LS/LE with 2 lines on VC1 and 4 on VC2, then FE. Expect independent counts of 2 and 4, `vc_o` tracking each packet, and `in_frame_o` = 3'b110 between FS and FE.
- **Error sequences:** FE in IDLE → code 2; LS, LS → code 5 with count 2; FE while IN_LINE → code 3 and state IDLE; FS in frame → code 1 with counter cleared.
- **Generic and ignored packets:** DT 0x0A, data 16'hBEEF → `generic_valid_o`, `generic_dt_o` = 2, `generic_data_o` = BEEF. VC3 header with NUM_VC = 2 → no output.
- **Reset and saturation:** Assert `rst_n_i` while IN_LINE → all outputs 0 and IDLE; the next FS works normally. Use LINE_CNT_W = 2 with 5 LS → count saturates at 3.
- **Frame-number check (with macro):** FS 1, 2, 4 → code 7 on the third FS. With FRAME_NUM_MAX = 3, the sequence 3 then 1 → no error. FS 0 → never an error.

Source files
------------

// File: rtl/csi2_data_types_pkg.sv
// Shared CSI-2 data-type codes plus the short-packet tracker's state and error enums.
package csi2_data_types_pkg;

    localparam logic [5:0] FRAME_START = 6'h00;
    localparam logic [5:0] FRAME_END   = 6'h01;
    localparam logic [5:0] LINE_START  = 6'h02;
    localparam logic [5:0] LINE_END    = 6'h03;

    localparam logic [5:0] GENERIC_SHORT_MIN = 6'h08;
    localparam logic [5:0] GENERIC_SHORT_MAX = 6'h0F;

    typedef enum logic [1:0] {
        VC_IDLE     = 2'd0,
        VC_IN_FRAME = 2'd1,
        VC_IN_LINE  = 2'd2
    } vc_state_t;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_FS_IN_FRAME   = 3'd1,
        ERR_FE_NO_FS      = 3'd2,
        ERR_LINE_UNTERM   = 3'd3,
        ERR_LS_NO_FS      = 3'd4,
        ERR_LS_IN_LINE    = 3'd5,
        ERR_LE_NO_LS      = 3'd6,
        ERR_FRAME_NUM_SEQ = 3'd7
    } short_pkt_err_t;

endpackage

// File: rtl/csi2_vc_frame_fsm.sv
// Frame/line state, numbers and line counter for a single virtual channel.
// Optional build macro: CSI2_FRAME_NUM_CHECK_EN adds the frame-number sequence check.
module csi2_vc_frame_fsm
    import csi2_data_types_pkg::*;
#(
    parameter int          LINE_CNT_W    = 16,
    parameter logic [15:0] FRAME_NUM_MAX = 16'hFFFF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  fs_i,
    input  logic                  fe_i,
    input  logic                  ls_i,
    input  logic                  le_i,
    input  logic [15:0]           data_field_i,
    output vc_state_t             state_o,
    output logic [15:0]           frame_number_o,
    output logic [15:0]           line_number_o,
    output logic [LINE_CNT_W-1:0] last_frame_lines_o,
    output short_pkt_err_t        err_code_o
);

    vc_state_t             state;
    logic [LINE_CNT_W-1:0] line_cnt;

`ifdef CSI2_FRAME_NUM_CHECK_EN
    logic [15:0] next_frame_num;
    logic        seq_err;

    // A zero on either side means "frame numbering not in use" and is never checked.
    assign next_frame_num = (frame_number_o == FRAME_NUM_MAX) ? 16'd1 : frame_number_o + 16'd1;
    assign seq_err        = (data_field_i != 16'd0) && (frame_number_o != 16'd0) &&
                            (data_field_i != next_frame_num);
`else
    logic unused_frame_num_max;
    assign unused_frame_num_max = ^FRAME_NUM_MAX;
`endif

    // Error verdict for the packet presented this cycle; the top level registers it.
    always_comb begin
        // NOTE: default first so every path assigns err_code_o and no latch is inferred.
        err_code_o = ERR_NONE;
        if (fs_i) begin
            if (state != VC_IDLE) err_code_o = ERR_FS_IN_FRAME;
`ifdef CSI2_FRAME_NUM_CHECK_EN
            else if (seq_err)     err_code_o = ERR_FRAME_NUM_SEQ;
`endif
        end else if (fe_i) begin
            if (state == VC_IDLE)         err_code_o = ERR_FE_NO_FS;
            else if (state == VC_IN_LINE) err_code_o = ERR_LINE_UNTERM;
        end else if (ls_i) begin
            if (state == VC_IDLE)         err_code_o = ERR_LS_NO_FS;
            else if (state == VC_IN_LINE) err_code_o = ERR_LS_IN_LINE;
        end else if (le_i) begin
            if (state != VC_IN_LINE)      err_code_o = ERR_LE_NO_LS;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state              <= VC_IDLE;
            frame_number_o     <= '0;
            line_number_o      <= '0;
            line_cnt           <= '0;
            last_frame_lines_o <= '0;
        end else if (fs_i) begin
            state          <= VC_IN_FRAME;
            frame_number_o <= data_field_i;
            line_cnt       <= '0;
        end else if (fe_i) begin
            if (state != VC_IDLE) begin
                state              <= VC_IDLE;
                last_frame_lines_o <= line_cnt;
            end
        end else if (ls_i) begin
            line_number_o <= data_field_i;
            if (state != VC_IDLE) begin
                state <= VC_IN_LINE;
                if (line_cnt != '1) line_cnt <= line_cnt + LINE_CNT_W'(1);
            end
        end else if (le_i) begin
            if (state == VC_IN_LINE) state <= VC_IN_FRAME;
        end
    end

    assign state_o = state;

endmodule

// File: rtl/csi2_short_pkt_tracker.sv
// Decodes CSI-2 sync/generic short packets and registers per-VC tracking results.
// Optional build macro: CSI2_FRAME_NUM_CHECK_EN enables frame-number sequence errors.
module csi2_short_pkt_tracker
    import csi2_data_types_pkg::*;
#(
    parameter int          NUM_VC        = 4,
    parameter int          LINE_CNT_W    = 16,
    parameter logic [15:0] FRAME_NUM_MAX = 16'hFFFF
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         header_valid_i,
    input  logic [1:0]                   virtual_channel_i,
    input  logic [5:0]                   data_type_i,
    input  logic [15:0]                  data_field_i,
    output logic                         frame_start_o,
    output logic                         frame_end_o,
    output logic                         line_start_o,
    output logic                         line_end_o,
    output logic [1:0]                   vc_o,
    output logic [16*NUM_VC-1:0]         frame_number_o,
    output logic [16*NUM_VC-1:0]         line_number_o,
    output logic [NUM_VC-1:0]            in_frame_o,
    output logic [LINE_CNT_W*NUM_VC-1:0] last_frame_lines_o,
    output logic                         generic_valid_o,
    output logic [2:0]                   generic_dt_o,
    output logic [15:0]                  generic_data_o,
    output logic                         err_o,
    output logic [2:0]                   err_code_o
);

    localparam logic [2:0] NUM_VC_L = 3'(NUM_VC);

    logic           hdr_ok;
    logic           is_fs;
    logic           is_fe;
    logic           is_ls;
    logic           is_le;
    logic           is_generic;
    short_pkt_err_t vc_err [NUM_VC];
    short_pkt_err_t sel_err;

    // Headers addressed to an untracked VC are dropped before any decode.
    assign hdr_ok     = header_valid_i && ({1'b0, virtual_channel_i} < NUM_VC_L);
    assign is_fs      = (data_type_i == FRAME_START);
    assign is_fe      = (data_type_i == FRAME_END);
    assign is_ls      = (data_type_i == LINE_START);
    assign is_le      = (data_type_i == LINE_END);
    assign is_generic = (data_type_i >= GENERIC_SHORT_MIN) && (data_type_i <= GENERIC_SHORT_MAX);

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic      hit;
        vc_state_t state;

        assign hit = hdr_ok && (virtual_channel_i == 2'(v));

        csi2_vc_frame_fsm #(
            .LINE_CNT_W    (LINE_CNT_W),
            .FRAME_NUM_MAX (FRAME_NUM_MAX)
        ) u_fsm (
            .clk_i              (clk_i),
            .rst_n_i            (rst_n_i),
            .fs_i               (hit && is_fs),
            .fe_i               (hit && is_fe),
            .ls_i               (hit && is_ls),
            .le_i               (hit && is_le),
            .data_field_i       (data_field_i),
            .state_o            (state),
            .frame_number_o     (frame_number_o[16*v +: 16]),
            .line_number_o      (line_number_o[16*v +: 16]),
            .last_frame_lines_o (last_frame_lines_o[LINE_CNT_W*v +: LINE_CNT_W]),
            .err_code_o         (vc_err[v])
        );

        assign in_frame_o[v] = (state != VC_IDLE);
    end

    always_comb begin
        sel_err = ERR_NONE;
        for (int v = 0; v < NUM_VC; v++) begin
            if (virtual_channel_i == 2'(v)) sel_err = vc_err[v];
        end
    end

    // err_code_o and the generic fields hold between events; strobes are single-cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_start_o   <= 1'b0;
            frame_end_o     <= 1'b0;
            line_start_o    <= 1'b0;
            line_end_o      <= 1'b0;
            vc_o            <= '0;
            generic_valid_o <= 1'b0;
            generic_dt_o    <= '0;
            generic_data_o  <= '0;
            err_o           <= 1'b0;
            err_code_o      <= '0;
        end else begin
            frame_start_o   <= hdr_ok && is_fs;
            frame_end_o     <= hdr_ok && is_fe;
            line_start_o    <= hdr_ok && is_ls;
            line_end_o      <= hdr_ok && is_le;
            generic_valid_o <= hdr_ok && is_generic;
            err_o           <= hdr_ok && (sel_err != ERR_NONE);
            if (hdr_ok) vc_o <= virtual_channel_i;
            if (hdr_ok && is_generic) begin
                generic_dt_o   <= data_type_i[2:0];
                generic_data_o <= data_field_i;
            end
            if (hdr_ok && (sel_err != ERR_NONE)) err_code_o <= sel_err;
        end
    end

endmodule

// File: tb/tb_csi2_short_pkt_tracker.sv
// Directed bench: DUT A uses default parameters, DUT B uses NUM_VC=2, LINE_CNT_W=2, FRAME_NUM_MAX=3.
module tb_csi2_short_pkt_tracker;

    localparam logic [5:0] DT_FS = 6'h00;
    localparam logic [5:0] DT_FE = 6'h01;
    localparam logic [5:0] DT_LS = 6'h02;
    localparam logic [5:0] DT_LE = 6'h03;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        a_valid, b_valid;
    logic [1:0]  a_vc, b_vc;
    logic [5:0]  a_dt, b_dt;
    logic [15:0] a_data, b_data;

    logic        a_fs, a_fe, a_ls, a_le, a_gen, a_err;
    logic [1:0]  a_vc_o;
    logic [63:0] a_frame_num, a_line_num, a_last;
    logic [3:0]  a_in_frame;
    logic [2:0]  a_gen_dt, a_err_code;
    logic [15:0] a_gen_data;

    logic        b_fs, b_fe, b_ls, b_le, b_gen, b_err;
    logic [1:0]  b_vc_o;
    logic [31:0] b_frame_num, b_line_num;
    logic [3:0]  b_last;
    logic [1:0]  b_in_frame;
    logic [2:0]  b_gen_dt, b_err_code;
    logic [15:0] b_gen_data;

    wire [5:0] a_flags = {a_fs, a_fe, a_ls, a_le, a_gen, a_err};
    wire [5:0] b_flags = {b_fs, b_fe, b_ls, b_le, b_gen, b_err};

    csi2_short_pkt_tracker u_dut_a (
        .clk_i (clk), .rst_n_i (rst_n), .header_valid_i (a_valid), .virtual_channel_i (a_vc),
        .data_type_i (a_dt), .data_field_i (a_data), .frame_start_o (a_fs), .frame_end_o (a_fe),
        .line_start_o (a_ls), .line_end_o (a_le), .vc_o (a_vc_o), .frame_number_o (a_frame_num),
        .line_number_o (a_line_num), .in_frame_o (a_in_frame), .last_frame_lines_o (a_last),
        .generic_valid_o (a_gen), .generic_dt_o (a_gen_dt), .generic_data_o (a_gen_data),
        .err_o (a_err), .err_code_o (a_err_code)
    );

    csi2_short_pkt_tracker #(.NUM_VC (2), .LINE_CNT_W (2), .FRAME_NUM_MAX (16'd3)) u_dut_b (
        .clk_i (clk), .rst_n_i (rst_n), .header_valid_i (b_valid), .virtual_channel_i (b_vc),
        .data_type_i (b_dt), .data_field_i (b_data), .frame_start_o (b_fs), .frame_end_o (b_fe),
        .line_start_o (b_ls), .line_end_o (b_le), .vc_o (b_vc_o), .frame_number_o (b_frame_num),
        .line_number_o (b_line_num), .in_frame_o (b_in_frame), .last_frame_lines_o (b_last),
        .generic_valid_o (b_gen), .generic_dt_o (b_gen_dt), .generic_data_o (b_gen_data),
        .err_o (b_err), .err_code_o (b_err_code)
    );

    // One header for one cycle; returns #1 after the capturing edge with outputs settled.
    task automatic send(input bit to_b, input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] data);
        @(negedge clk);
        if (to_b) begin
            b_valid = 1'b1; b_vc = vc; b_dt = dt; b_data = data;
        end else begin
            a_valid = 1'b1; a_vc = vc; a_dt = dt; a_data = data;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        a_valid = 1'b0; b_valid = 1'b0;
        a_vc = '0; a_dt = '0; a_data = '0; b_vc = '0; b_dt = '0; b_data = '0;
        rst_n = 1'b0;
        #22;
        tests_run++;
        if ({a_flags, a_vc_o, a_gen_dt, a_err_code, a_gen_data} !== 30'd0) begin
            tests_failed++; $display("FAIL reset_a_outputs got %h exp 0", {a_flags, a_vc_o, a_gen_dt, a_err_code, a_gen_data});
        end
        tests_run++;
        if ({a_frame_num, a_line_num, a_last, a_in_frame} !== 196'd0) begin
            tests_failed++; $display("FAIL reset_a_tracking got %h exp 0", {a_frame_num, a_line_num, a_last, a_in_frame});
        end
        tests_run++;
        if ({b_flags, b_vc_o, b_in_frame, b_last, b_frame_num} !== 46'd0) begin
            tests_failed++; $display("FAIL reset_b_outputs got %h exp 0", {b_flags, b_vc_o, b_in_frame, b_last, b_frame_num});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal_frame();
        send(0, 2'd0, DT_FS, 16'd5);
        tests_run++;
        if (a_flags !== 6'b100000) begin tests_failed++; $display("FAIL normal_fs_flags got %b exp 100000", a_flags); end
        tests_run++;
        if (a_frame_num[15:0] !== 16'd5 || a_in_frame !== 4'b0001) begin
            tests_failed++; $display("FAIL normal_fs_state got fn=%0d inf=%b exp fn=5 inf=0001", a_frame_num[15:0], a_in_frame);
        end
        idle();
        tests_run++;
        if (a_flags !== 6'b000000) begin tests_failed++; $display("FAIL normal_strobe_width got %b exp 000000", a_flags); end
        for (int n = 1; n <= 3; n++) begin
            send(0, 2'd0, DT_LS, 16'(n));
            tests_run++;
            if (a_flags !== 6'b001000 || a_line_num[15:0] !== 16'(n)) begin
                tests_failed++; $display("FAIL normal_ls%0d got flags=%b ln=%0d exp 001000 ln=%0d", n, a_flags, a_line_num[15:0], n);
            end
            send(0, 2'd0, DT_LE, 16'd0);
            tests_run++;
            if (a_flags !== 6'b000100) begin tests_failed++; $display("FAIL normal_le%0d got %b exp 000100", n, a_flags); end
        end
        send(0, 2'd0, DT_FE, 16'd0);
        tests_run++;
        if (a_flags !== 6'b010000) begin tests_failed++; $display("FAIL normal_fe_flags got %b exp 010000", a_flags); end
        tests_run++;
        if (a_last[15:0] !== 16'd3 || a_line_num[15:0] !== 16'd3 || a_frame_num[15:0] !== 16'd5 || a_in_frame !== 4'b0000) begin
            tests_failed++;
            $display("FAIL normal_fe_state got last=%0d ln=%0d fn=%0d inf=%b exp 3 3 5 0000", a_last[15:0], a_line_num[15:0], a_frame_num[15:0], a_in_frame);
        end
    endtask

    task automatic test_interleaved();
        logic [1:0] seq_vc [12];
        logic       seq_ls [12];
        seq_vc = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        seq_ls = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        send(0, 2'd1, DT_FS, 16'd10);
        tests_run++;
        if (a_vc_o !== 2'd1 || a_flags !== 6'b100000) begin tests_failed++; $display("FAIL inter_fs1 got vc=%0d flags=%b exp 1 100000", a_vc_o, a_flags); end
        send(0, 2'd2, DT_FS, 16'd20);
        tests_run++;
        if (a_vc_o !== 2'd2 || a_in_frame !== 4'b0110) begin tests_failed++; $display("FAIL inter_fs2 got vc=%0d inf=%b exp 2 0110", a_vc_o, a_in_frame); end
        for (int i = 0; i < 12; i++) begin
            send(0, seq_vc[i], seq_ls[i] ? DT_LS : DT_LE, 16'(i));
            tests_run++;
            if (a_vc_o !== seq_vc[i] || a_flags !== (seq_ls[i] ? 6'b001000 : 6'b000100)) begin
                tests_failed++; $display("FAIL inter_step%0d got vc=%0d flags=%b exp vc=%0d ls=%0d", i, a_vc_o, a_flags, seq_vc[i], seq_ls[i]);
            end
        end
        tests_run++;
        if (a_in_frame !== 4'b0110) begin tests_failed++; $display("FAIL inter_in_frame got %b exp 0110", a_in_frame); end
        send(0, 2'd1, DT_FE, 16'd0);
        send(0, 2'd2, DT_FE, 16'd0);
        tests_run++;
        if (a_last[31:16] !== 16'd2 || a_last[47:32] !== 16'd4 || a_in_frame !== 4'b0000) begin
            tests_failed++; $display("FAIL inter_counts got vc1=%0d vc2=%0d inf=%b exp 2 4 0000", a_last[31:16], a_last[47:32], a_in_frame);
        end
    endtask

    task automatic test_errors();
        logic [5:0]  t_dt   [13];
        logic [15:0] t_data [13];
        logic [5:0]  t_flag [13];
        logic [2:0]  t_code [13];
        logic        t_inf  [13];
        t_dt   = '{DT_FE, DT_FS, DT_LS, DT_LS, DT_FE, DT_FS, DT_LS, DT_FS, DT_FE, DT_LS, DT_LE, DT_FS, DT_LE};
        t_data = '{16'd0, 16'd7, 16'd1, 16'd2, 16'd0, 16'd8, 16'd1, 16'd9, 16'd0, 16'h55, 16'd0, 16'd10, 16'd0};
        t_flag = '{6'b010001, 6'b100000, 6'b001000, 6'b001001, 6'b010001, 6'b100000, 6'b001000,
                   6'b100001, 6'b010000, 6'b001001, 6'b000101, 6'b100000, 6'b000101};
        t_code = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd3, 3'd3, 3'd3, 3'd1, 3'd1, 3'd4, 3'd6, 3'd6, 3'd6};
        t_inf  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 13; i++) begin
            send(0, 2'd3, t_dt[i], t_data[i]);
            tests_run++;
            if (a_flags !== t_flag[i] || a_err_code !== t_code[i] || a_in_frame[3] !== t_inf[i] || a_vc_o !== 2'd3) begin
                tests_failed++;
                $display("FAIL err_step%0d got flags=%b code=%0d inf=%b exp flags=%b code=%0d inf=%b", i, a_flags, a_err_code, a_in_frame[3], t_flag[i], t_code[i], t_inf[i]);
            end
            if (i == 4) begin
                tests_run++;
                if (a_last[63:48] !== 16'd2) begin tests_failed++; $display("FAIL err_ls_in_line_count got %0d exp 2", a_last[63:48]); end
            end
            if (i == 7) begin
                tests_run++;
                if (a_frame_num[63:48] !== 16'd9) begin tests_failed++; $display("FAIL err_fs_restart_num got %0d exp 9", a_frame_num[63:48]); end
            end
            if (i == 8) begin
                tests_run++;
                if (a_last[63:48] !== 16'd0) begin tests_failed++; $display("FAIL err_fs_restart_cnt got %0d exp 0", a_last[63:48]); end
            end
            if (i == 9) begin
                tests_run++;
                if (a_line_num[63:48] !== 16'h55) begin tests_failed++; $display("FAIL err_ls_idle_num got %h exp 0055", a_line_num[63:48]); end
            end
        end
        idle();
        tests_run++;
        if (a_flags !== 6'b000000 || a_err_code !== 3'd6) begin tests_failed++; $display("FAIL err_code_hold got flags=%b code=%0d exp 000000 6", a_flags, a_err_code); end
        send(0, 2'd3, DT_FE, 16'd0);
        tests_run++;
        if (a_flags !== 6'b010000 || a_in_frame[3] !== 1'b0) begin tests_failed++; $display("FAIL err_close got flags=%b inf=%b exp 010000 0", a_flags, a_in_frame[3]); end
    endtask

    task automatic test_generic_ignored();
        send(0, 2'd2, 6'h0A, 16'hBEEF);
        tests_run++;
        if (a_flags !== 6'b000010 || a_gen_dt !== 3'd2 || a_gen_data !== 16'hBEEF || a_vc_o !== 2'd2) begin
            tests_failed++; $display("FAIL gen_0a got flags=%b dt=%0d data=%h vc=%0d exp 000010 2 beef 2", a_flags, a_gen_dt, a_gen_data, a_vc_o);
        end
        send(0, 2'd0, 6'h0F, 16'h0001);
        tests_run++;
        if (a_flags !== 6'b000010 || a_gen_dt !== 3'd7 || a_gen_data !== 16'h0001) begin
            tests_failed++; $display("FAIL gen_0f got flags=%b dt=%0d data=%h exp 000010 7 0001", a_flags, a_gen_dt, a_gen_data);
        end
        send(0, 2'd1, 6'h07, 16'h1111);
        tests_run++;
        if (a_flags !== 6'b000000) begin tests_failed++; $display("FAIL gen_dt07_ignored got %b exp 000000", a_flags); end
        send(0, 2'd1, 6'h10, 16'h2222);
        tests_run++;
        if (a_flags !== 6'b000000) begin tests_failed++; $display("FAIL gen_dt10_ignored got %b exp 000000", a_flags); end
        send(0, 2'd1, 6'h2A, 16'h3333);
        tests_run++;
        if (a_flags !== 6'b000000 || a_in_frame !== 4'b0000) begin tests_failed++; $display("FAIL long_pkt_ignored got %b inf=%b exp 000000 0000", a_flags, a_in_frame); end
        send(1, 2'd3, DT_FS, 16'd1);
        tests_run++;
        if (b_flags !== 6'b000000 || b_vc_o !== 2'd0 || b_in_frame !== 2'b00 || b_frame_num !== 32'd0) begin
            tests_failed++; $display("FAIL vc3_ignored got flags=%b vc=%0d inf=%b fn=%h exp all 0", b_flags, b_vc_o, b_in_frame, b_frame_num);
        end
    endtask

    task automatic test_reset_midframe();
        send(0, 2'd1, DT_FS, 16'd11);
        send(0, 2'd1, DT_LS, 16'd1);
        tests_run++;
        if (a_in_frame !== 4'b0010 || a_vc_o !== 2'd1) begin tests_failed++; $display("FAIL midrst_pre got inf=%b vc=%0d exp 0010 1", a_in_frame, a_vc_o); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (a_in_frame !== 4'b0000 || a_vc_o !== 2'd0 || a_frame_num !== 64'd0 || a_last !== 64'd0 || a_flags !== 6'd0) begin
            tests_failed++; $display("FAIL midrst_async got inf=%b vc=%0d fn=%h last=%h flags=%b exp all 0", a_in_frame, a_vc_o, a_frame_num, a_last, a_flags);
        end
        idle();
        tests_run++;
        if (a_flags !== 6'd0 || a_last !== 64'd0) begin tests_failed++; $display("FAIL midrst_no_fe got flags=%b last=%h exp 0", a_flags, a_last); end
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 2'd1, DT_FS, 16'd2);
        tests_run++;
        if (a_flags !== 6'b100000 || a_frame_num[31:16] !== 16'd2 || a_in_frame !== 4'b0010) begin
            tests_failed++; $display("FAIL midrst_fs got flags=%b fn=%0d inf=%b exp 100000 2 0010", a_flags, a_frame_num[31:16], a_in_frame);
        end
        send(0, 2'd1, DT_LS, 16'd1);
        send(0, 2'd1, DT_LE, 16'd0);
        send(0, 2'd1, DT_FE, 16'd0);
        tests_run++;
        if (a_flags !== 6'b010000 || a_last[31:16] !== 16'd1) begin tests_failed++; $display("FAIL midrst_fe got flags=%b last=%0d exp 010000 1", a_flags, a_last[31:16]); end
    endtask

    task automatic test_saturation();
        send(1, 2'd1, DT_FS, 16'd1);
        for (int n = 0; n < 5; n++) begin
            send(1, 2'd1, DT_LS, 16'(n));
            send(1, 2'd1, DT_LE, 16'd0);
        end
        send(1, 2'd1, DT_FE, 16'd0);
        tests_run++;
        if (b_flags !== 6'b010000 || b_last[3:2] !== 2'd3 || b_last[1:0] !== 2'd0) begin
            tests_failed++; $display("FAIL sat_count got flags=%b vc1=%0d vc0=%0d exp 010000 3 0", b_flags, b_last[3:2], b_last[1:0]);
        end
    endtask

    task automatic test_frame_num();
        logic [5:0]  t_dt   [13];
        logic [15:0] t_data [13];
        logic [5:0]  t_flag [13];
        logic [5:0]  seq_flag;
        t_dt   = '{DT_FS, DT_FE, DT_FS, DT_FE, DT_FS, DT_FE, DT_FS, DT_FE, DT_FS, DT_FE, DT_FS, DT_FS, DT_FE};
        t_data = '{16'd1, 16'd0, 16'd2, 16'd0, 16'd4, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd1, 16'd5, 16'd0};
`ifdef CSI2_FRAME_NUM_CHECK_EN
        seq_flag = 6'b100001;
`else
        seq_flag = 6'b100000;
`endif
        t_flag = '{6'b100000, 6'b010000, 6'b100000, 6'b010000, seq_flag, 6'b010000, 6'b100000,
                   6'b010000, 6'b100000, 6'b010000, 6'b100000, 6'b100001, 6'b010000};
        for (int i = 0; i < 13; i++) begin
            send(1, 2'd0, t_dt[i], t_data[i]);
            tests_run++;
            if (b_flags !== t_flag[i]) begin tests_failed++; $display("FAIL fnum_step%0d got %b exp %b", i, b_flags, t_flag[i]); end
            if (i == 4) begin
                tests_run++;
                if (b_frame_num[15:0] !== 16'd4) begin tests_failed++; $display("FAIL fnum_load got %0d exp 4", b_frame_num[15:0]); end
`ifdef CSI2_FRAME_NUM_CHECK_EN
                tests_run++;
                if (b_err_code !== 3'd7) begin tests_failed++; $display("FAIL fnum_seq_code got %0d exp 7", b_err_code); end
`endif
            end
            if (i == 11) begin
                tests_run++;
                if (b_err_code !== 3'd1) begin tests_failed++; $display("FAIL fnum_priority got %0d exp 1", b_err_code); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_interleaved();
        test_errors();
        test_generic_ignored();
        test_reset_midframe();
        test_saturation();
        test_frame_num();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
